// File: rtl/stack_game_pkg.sv
// rtl/stack_game_pkg.sv - shared types, status codes and widths for the stacking game
package stack_game_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int CH_W  = 4;
    localparam int LVL_W = 3;
    localparam int GS_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        CHECK,
        PLACE,
        MISS,
        WIN,
        LOSE
    } state_t;

    localparam logic [GS_W-1:0] GS_IDLE = 2'b00;
    localparam logic [GS_W-1:0] GS_PLAY = 2'b01;
    localparam logic [GS_W-1:0] GS_WIN  = 2'b10;
    localparam logic [GS_W-1:0] GS_LOSE = 2'b11;

    function automatic logic [GS_W-1:0] status_of(input state_t s);
        case (s)
            IDLE:    return GS_IDLE;
            WIN:     return GS_WIN;
            LOSE:    return GS_LOSE;
            default: return GS_PLAY;
        endcase
    endfunction

endpackage

// File: rtl/stack_game_core_if.sv
// rtl/stack_game_core_if.sv - control inputs and game-state outputs of the stacking game
interface stack_game_core_if;
    import stack_game_pkg::*;

    logic             sync;
    logic             start;
    logic             drop;
    logic [X_W-1:0]   x;
    logic [X_W-1:0]   prev_x;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   blk_w;
    logic [X_W-1:0]   score;
    logic [CH_W-1:0]  chances;
    logic [LVL_W-1:0] level;
    logic             overlap;
    logic [GS_W-1:0]  game_status;

    modport master (
        output sync, start, drop,
        input  x, prev_x, y, blk_w, score, chances, level, overlap, game_status
    );

    modport slave (
        input  sync, start, drop,
        output x, prev_x, y, blk_w, score, chances, level, overlap, game_status
    );

endinterface

// File: rtl/stack_overlap_calc.sv
// rtl/stack_overlap_calc.sv - horizontal overlap of the moving block against the top placed block
module stack_overlap_calc
    import stack_game_pkg::*;
(
    input  logic [X_W-1:0] x,
    input  logic [X_W-1:0] blk_w,
    input  logic [X_W-1:0] prev_x,
    input  logic [X_W-1:0] prev_w,
    output logic [X_W-1:0] lo,
    output logic [X_W-1:0] width,
    output logic           hit
);

    logic [X_W:0] cur_hi;
    logic [X_W:0] prev_hi;
    logic [X_W:0] hi;
    logic [X_W:0] lo_ext;

    // Right edges can exceed 255, so they are formed one bit wider.
    always_comb begin
        cur_hi  = {1'b0, x} + {1'b0, blk_w};
        prev_hi = {1'b0, prev_x} + {1'b0, prev_w};
        lo_ext  = (x > prev_x) ? {1'b0, x} : {1'b0, prev_x};
        hi      = (cur_hi < prev_hi) ? cur_hi : prev_hi;
        hit     = hi > lo_ext;
        lo      = lo_ext[X_W-1:0];
        width   = hit ? X_W'(hi - lo_ext) : '0;
    end

endmodule

// File: rtl/stack_game_core.sv
// rtl/stack_game_core.sv - stacking game FSM and datapath: move, drop, place/miss, win/lose
module stack_game_core
    import stack_game_pkg::*;
#(
    parameter int SCREEN_W     = 160,
    parameter int BLOCK_W_INIT = 40,
    parameter int ROW_H        = 4,
    parameter int Y_BASE       = 116,
    parameter int N_ROWS       = 20,
    parameter int CHANCES_INIT = 3,
    parameter int LEVEL_ROWS   = 4,
    parameter int MAX_STEP     = 4,
    parameter int SHRINK_EN    = 1
)
(
    input  logic          clk,
    input  logic          reset,
    stack_game_core_if.slave bus
);

    localparam logic [X_W-1:0]  PREV_X_INIT = X_W'((SCREEN_W - BLOCK_W_INIT) / 2);
    localparam logic [X_W-1:0]  BLK_W_INIT  = X_W'(BLOCK_W_INIT);
    localparam logic [Y_W-1:0]  Y_INIT      = Y_W'(Y_BASE);
    localparam logic [Y_W-1:0]  ROW_DY      = Y_W'(ROW_H);
    localparam logic [CH_W-1:0] CH_INIT     = CH_W'(CHANCES_INIT);
    localparam logic [X_W:0]    SCREEN      = (X_W+1)'(SCREEN_W);
    localparam logic [X_W:0]    STEP_MAX    = (X_W+1)'(MAX_STEP);
    localparam logic [X_W-1:0]  WIN_ROWS    = X_W'(N_ROWS);

    state_t state, state_next;

    logic [X_W-1:0]   x_r, prev_x_r, prev_w_r, blk_w_r, score_r;
    logic [Y_W-1:0]   y_r;
    logic [CH_W-1:0]  chances_r;
    logic [LVL_W-1:0] level_r;
    logic             overlap_r;
    logic [GS_W-1:0]  status_r;
    logic             dir_left;

    logic [X_W-1:0]   ov_lo, ov_width;
    logic             ov_hit;

    logic [X_W:0]     step;
    logic [X_W:0]     x_ext;
    logic [X_W:0]     right_lim;
    logic [X_W-1:0]   score_new;
    logic [X_W-1:0]   level_q;
    logic [LVL_W-1:0] level_new;
    logic [CH_W-1:0]  chances_new;

    stack_overlap_calc u_overlap (
        .x      (x_r),
        .blk_w  (blk_w_r),
        .prev_x (prev_x_r),
        .prev_w (prev_w_r),
        .lo     (ov_lo),
        .width  (ov_width),
        .hit    (ov_hit)
    );

    always_comb begin
        step        = ({6'd0, level_r} + 9'd1 > STEP_MAX) ? STEP_MAX : {6'd0, level_r} + 9'd1;
        x_ext       = {1'b0, x_r};
        right_lim   = SCREEN - {1'b0, blk_w_r};
        score_new   = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
        level_q     = X_W'(int'(score_new) / LEVEL_ROWS);
        level_new   = (level_q > 8'd7) ? 3'd7 : level_q[LVL_W-1:0];
        chances_new = chances_r - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, WIN, LOSE: if (bus.start) state_next = MOVE;
            MOVE:            if (bus.drop) state_next = CHECK;
            CHECK:           state_next = ov_hit ? PLACE : MISS;
            PLACE:           state_next = (score_new == WIN_ROWS) ? WIN : MOVE;
            MISS:            state_next = (chances_new == '0) ? LOSE : MOVE;
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r       <= '0;
            prev_x_r  <= PREV_X_INIT;
            prev_w_r  <= BLK_W_INIT;
            blk_w_r   <= BLK_W_INIT;
            y_r       <= Y_INIT;
            score_r   <= '0;
            level_r   <= '0;
            chances_r <= CH_INIT;
            overlap_r <= 1'b0;
            status_r  <= GS_IDLE;
            dir_left  <= 1'b0;
        end else begin
            overlap_r <= 1'b0;
            status_r  <= status_of(state_next);
            case (state)
                IDLE, WIN, LOSE: begin
                    if (bus.start) begin
                        x_r       <= '0;
                        prev_x_r  <= PREV_X_INIT;
                        prev_w_r  <= BLK_W_INIT;
                        blk_w_r   <= BLK_W_INIT;
                        y_r       <= Y_INIT;
                        score_r   <= '0;
                        level_r   <= '0;
                        chances_r <= CH_INIT;
                        dir_left  <= 1'b0;
                    end
                end
                MOVE: begin
                    // A drop freezes the block this cycle even if a tick arrives with it.
                    if (!bus.drop && bus.sync) begin
                        if (!dir_left) begin
                            if (x_ext + step > right_lim) begin
                                x_r      <= right_lim[X_W-1:0];
                                dir_left <= 1'b1;
                            end else begin
                                x_r <= x_r + step[X_W-1:0];
                            end
                        end else begin
                            if (x_ext < step) begin
                                x_r      <= '0;
                                dir_left <= 1'b0;
                            end else begin
                                x_r <= x_r - step[X_W-1:0];
                            end
                        end
                    end
                end
                PLACE: begin
                    overlap_r <= 1'b1;
                    prev_x_r  <= ov_lo;
                    prev_w_r  <= ov_width;
                    if (SHRINK_EN != 0) blk_w_r <= ov_width;
                    score_r   <= score_new;
                    y_r       <= y_r - ROW_DY;
                    x_r       <= '0;
                    dir_left  <= 1'b0;
                    level_r   <= level_new;
                end
                MISS: begin
                    chances_r <= chances_new;
                    x_r       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.x           = x_r;
    assign bus.prev_x      = prev_x_r;
    assign bus.y           = y_r;
    assign bus.blk_w       = blk_w_r;
    assign bus.score       = score_r;
    assign bus.chances     = chances_r;
    assign bus.level       = level_r;
    assign bus.overlap     = overlap_r;
    assign bus.game_status = status_r;

endmodule

// File: tb/tb_stack_game_core.sv
// tb/tb_stack_game_core.sv - randomized scoreboard bench for stack_game_core against a game-rule model
module tb_stack_game_core;

    localparam int SW = 160, BW = 40, RH = 4, YB = 116, NR = 20;
    localparam int CH0 = 3, LR = 4, MS = 4, SH = 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] px;
        logic [6:0] y;
        logic [7:0] w;
        logic [7:0] score;
        logic [3:0] ch;
        logic [2:0] lvl;
        logic       ovl;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stack_game_core_if bus ();

    stack_game_core #(
        .SCREEN_W(SW), .BLOCK_W_INIT(BW), .ROW_H(RH), .Y_BASE(YB), .N_ROWS(NR),
        .CHANCES_INIT(CH0), .LEVEL_ROWS(LR), .MAX_STEP(MS), .SHRINK_EN(SH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Game model: the outcome of a drop is resolved two ticks after it is accepted.
    int m_x, m_px, m_pw, m_w, m_y, m_score, m_ch, m_lvl, m_ovl, m_left, m_status, m_busy;

    task automatic model_init();
        m_x = 0; m_px = (SW - BW) / 2; m_pw = BW; m_w = BW; m_y = YB;
        m_score = 0; m_lvl = 0; m_ch = CH0; m_left = 0; m_busy = 0;
    endtask

    task automatic model_resolve();
        int lo, hi;
        lo = (m_x > m_px) ? m_x : m_px;
        hi = (m_x + m_w < m_px + m_pw) ? m_x + m_w : m_px + m_pw;
        m_x = 0;
        if (hi > lo) begin
            m_px = lo; m_pw = hi - lo;
            if (SH != 0) m_w = hi - lo;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_y = m_y - RH; m_left = 0;
            m_lvl = (m_score / LR > 7) ? 7 : m_score / LR;
            m_ovl = 1;
            if (m_score == NR) m_status = 2;
        end else begin
            m_ch = m_ch - 1;
            if (m_ch == 0) m_status = 3;
        end
    endtask

    task automatic model_edge(input bit st, input bit dr, input bit sy);
        int step;
        m_ovl = 0;
        step = (1 + m_lvl > MS) ? MS : 1 + m_lvl;
        if (m_status != 1) begin
            if (st) begin model_init(); m_status = 1; end
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) model_resolve();
        end else if (dr) begin
            m_busy = 2;
        end else if (sy) begin
            if (m_left == 0) begin
                if (m_x + step > SW - m_w) begin m_x = SW - m_w; m_left = 1; end
                else m_x = m_x + step;
            end else begin
                if (m_x < step) begin m_x = 0; m_left = 0; end
                else m_x = m_x - step;
            end
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        e.x = 8'(m_x); e.px = 8'(m_px); e.y = 7'(m_y); e.w = 8'(m_w);
        e.score = 8'(m_score); e.ch = 4'(m_ch); e.lvl = 3'(m_lvl);
        e.ovl = 1'(m_ovl); e.st = 2'(m_status);
        return e;
    endfunction

    task automatic check_outputs(input string name, input exp_t e);
        exp_t a;
        a = '{bus.x, bus.prev_x, bus.y, bus.blk_w, bus.score, bus.chances,
              bus.level, bus.overlap, bus.game_status};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got x=%0d px=%0d y=%0d w=%0d sc=%0d ch=%0d lv=%0d ov=%0d st=%0d expected x=%0d px=%0d y=%0d w=%0d sc=%0d ch=%0d lv=%0d ov=%0d st=%0d",
                     name, $time, a.x, a.px, a.y, a.w, a.score, a.ch, a.lvl, a.ovl, a.st,
                     e.x, e.px, e.y, e.w, e.score, e.ch, e.lvl, e.ovl, e.st);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_outputs("cycle", e);
            end
        end
    end

    task automatic cycle(input bit st, input bit dr, input bit sy);
        @(negedge clk); #1;
        reset = 1'b0;
        bus.start = st; bus.drop = dr; bus.sync = sy;
        model_edge(st, dr, sy);
        exp_q.push_back(make_exp());
    endtask

    task automatic syncs(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        bus.start = 1'b0; bus.drop = 1'b0; bus.sync = 1'b0;
        reset = 1'b1;
        model_init(); m_status = 0; m_ovl = 0;
        #1 check_outputs("async_reset", make_exp());
        exp_q.push_back(make_exp());
    endtask

    initial begin : stimulus
        bus.start = 1'b0; bus.drop = 1'b0; bus.sync = 1'b0;
        model_init(); m_status = 0; m_ovl = 0;
        @(negedge clk); #1;
        check_outputs("reset_state", make_exp());

        // Centred drop on the base
        cycle(1, 0, 0); syncs(60); cycle(0, 1, 0); idles(3);

        // Offset drop shrinks the block
        do_reset(); cycle(1, 0, 0); syncs(70); cycle(0, 1, 0); idles(3);

        // Three misses then frozen outputs in LOSE
        do_reset(); cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) begin cycle(0, 1, 0); idles(3); end
        for (int i = 0; i < 20; i++) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Drop and sync together, then a bounce run
        do_reset(); cycle(1, 0, 0); syncs(5); cycle(0, 1, 1); idles(3);
        do_reset(); cycle(1, 0, 0); syncs(125);

        // Async reset while the PLACE update is pending
        do_reset(); cycle(1, 0, 0); syncs(60); cycle(0, 1, 0); idles(1);
        do_reset(); idles(2);

        // Twenty perfect drops to win, frozen, then restart
        cycle(1, 0, 0);
        for (int r = 0; r < NR; r++) begin
            for (int g = 0; g < 400 && m_x != m_px; g++) cycle(0, 0, 1);
            if (m_x != m_px) begin
                n_vec++; n_bad++;
                $display("FAIL win_align row=%0d model_x=%0d target=%0d", r, m_x, m_px);
            end
            cycle(0, 1, 0); idles(3);
        end
        for (int i = 0; i < 10; i++) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cycle(1, 0, 0); idles(2);

        // Random play
        for (int i = 0; i < 4000; i++)
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)));

        idles(1);
        @(negedge clk); @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_game_core.md
STACK_GAME_CORE -- requirements
Module: stack_game_core

Interface
REQ-001 Parameter SCREEN_W, default 160: playfield width in pixels.
REQ-002 Parameter BLOCK_W_INIT, default 40: width of the base platform and of the first moving block.
REQ-003 Parameter ROW_H, default 4: block height in pixels, which is the y decrement per placed row.
REQ-004 Parameter Y_BASE, default 116: y of the first moving row.
REQ-005 Parameter N_ROWS, default 20: number of placed rows that wins the game.
REQ-006 Parameter CHANCES_INIT, default 3: starting misses allowed.
REQ-007 Parameter LEVEL_ROWS, default 4: number of placed rows per speed level.
REQ-008 Parameter MAX_STEP, default 4: maximum x step per tick.
REQ-009 Parameter SHRINK_EN, default 1: 1 = block width shrinks to the overlap width; 0 = width is fixed.
REQ-010 clk  in  1  system clock; single clock domain.
REQ-011 reset  in  1  asynchronous, active-high reset.
REQ-012 sync  in  1  one-cycle movement tick from the delay counter.
REQ-013 start  in  1  one-cycle pulse that starts or restarts a game.
REQ-014 drop  in  1  one-cycle, debounced drop request.
REQ-015 x  out  8  left edge of the moving block.
REQ-016 prev_x  out  8  left edge of the top placed block.
REQ-017 y  out  7  y of the moving row.
REQ-018 blk_w  out  8  current block width.
REQ-019 score  out  8  number of rows placed.
REQ-020 chances  out  4  remaining chances.
REQ-021 level  out  3  current speed level.
REQ-022 overlap  out  1  one-cycle pulse on a successful placement.
REQ-023 game_status  out  2  00 = idle, 01 = playing, 10 = win, 11 = lose.

Function
REQ-024 The FSM SHALL have exactly these states: IDLE, MOVE, CHECK, PLACE, MISS, WIN, LOSE; game_status SHALL be 00 in IDLE, 01 in MOVE/CHECK/PLACE/MISS, 10 in WIN, 11 in LOSE.
REQ-025 In IDLE, WIN or LOSE, start SHALL load all reset values (REQ-037) and enter MOVE on the next cycle.
REQ-026 In MOVE, on each sync the block SHALL move by step = min(1 + level, MAX_STEP) in the current direction; the direction after reset or a new row is right.
REQ-027 Right-edge bounce: if x + step > SCREEN_W - blk_w, then x = SCREEN_W - blk_w and the direction reverses, in the same cycle.
REQ-028 Left-edge bounce: if x < step, then x = 0 and the direction reverses, in the same cycle.
REQ-029 On drop in MOVE, the FSM SHALL enter CHECK on the next cycle with no movement that cycle; drop SHALL take priority over a coincident sync.
REQ-030 In CHECK (one cycle), the block SHALL compute lo = max(x, prev_x) and hi = min(x + blk_w, prev_x + prev_w), using 9-bit sums; overlap exists iff hi > lo.
REQ-031 PLACE (one cycle) SHALL, in that cycle:
 - pulse overlap;
 - set prev_x = lo and prev_w = hi - lo;
 - set blk_w = hi - lo if SHRINK_EN, otherwise leave blk_w unchanged;
 - increment score, saturating at 255;
 - set y = y - ROW_H;
 - set x = 0 and direction = right;
 - set level = min(score_new / LEVEL_ROWS, 7).
REQ-032 After PLACE, the FSM SHALL go to WIN if score_new == N_ROWS, otherwise to MOVE.
REQ-033 MISS (one cycle) SHALL decrement chances and set x = 0, leaving row, y and prev_* unchanged; the FSM SHALL then go to LOSE if chances_new == 0, otherwise to MOVE.
REQ-034 drop SHALL be ignored outside MOVE; sync SHALL be ignored outside MOVE.
REQ-035 All outputs SHALL be registered; every output SHALL hold in WIN and LOSE until start.

Reset
REQ-036 reset SHALL act asynchronously, at any time including mid-CHECK/PLACE, and force the state to IDLE.
REQ-037 Reset values SHALL be:
 - x = 0;
 - prev_x = (SCREEN_W - BLOCK_W_INIT)/2, i.e. 60 at defaults;
 - prev_w = blk_w = BLOCK_W_INIT;
 - y = Y_BASE;
 - score = 0, level = 0;
 - chances = CHANCES_INIT;
 - overlap = 0;
 - game_status = 00;
 - direction = right.

Structure
REQ-038 Package stack_game_pkg SHALL hold the state enum, the game_status codes and the width constants.
REQ-039 The overlap arithmetic SHALL be one combinational sub-module, stack_overlap_calc (inputs x, blk_w, prev_x, prev_w; outputs lo, width, hit); the FSM and datapath SHALL stay in stack_game_core.

Verification
REQ-040 Reset, then start; drop at x = 60 -> overlap pulse, prev_x = 60, blk_w = 40, score = 1, y = 112, x = 0.
REQ-041 Drop at x = 70 on the base -> prev_x = 70, blk_w = 30 (SHRINK_EN = 1) or blk_w = 40 (SHRINK_EN = 0).
REQ-042 Drop at x = 0 on the base -> no overlap pulse, chances 3 -> 2, y stays 116; three misses -> game_status = 11 and outputs frozen.
REQ-043 Bounce with blk_w = 40 and step 1: x runs 0 -> 120 -> 119; with level 3 (step 4) and x = 118, the next tick gives x = 120 and direction left.
REQ-044 N_ROWS = 2, two perfect drops -> game_status = 10; a following start -> status 01 and all REQ-037 values restored.
REQ-045 Drop and sync in the same cycle -> x unchanged, CHECK entered; reset asserted in PLACE -> IDLE immediately, score = 0.
